// File: rtl/sap1_sequencer.sv
// sap1_sequencer: SAP-1 T-state control sequencer driving the datapath load/enable strobes
module sap1_sequencer #(
  parameter bit SKIP_NOP = 1'b0
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [3:0] opcode,
  output logic       pc_inc,
  output logic       n_pc_en,
  output logic       n_mar_load,
  output logic       n_ram_en,
  output logic       n_ir_load,
  output logic       n_ir_en,
  output logic       n_a_load,
  output logic       n_a_en,
  output logic       sub,
  output logic       n_alu_en,
  output logic       n_b_load,
  output logic       n_out_load,
  output logic [2:0] tstate,
  output logic       halted
);
  localparam logic [2:0] IDLE = 3'd0, T1 = 3'd1, T2 = 3'd2, T3 = 3'd3,
                         T4 = 3'd4, T5 = 3'd5, T6 = 3'd6, HALT = 3'd7;
  localparam logic [3:0] LDA = 4'h0, ADD = 4'h1, SUB = 4'h2, OUT = 4'hE, HLT = 4'hF;

  logic [2:0] state, next;
  logic       alu_op;

  assign alu_op = (opcode == ADD) || (opcode == SUB);
  assign tstate = state;
  assign halted = (state == HALT);

  // state register, reset drops straight back to IDLE
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= next;
  end

  // next state: HLT traps at T4, SKIP_NOP shortcuts back to T1 once nothing is left to do
  always_comb begin
    next = state + 3'd1;
    case (state)
      T4:      next = (opcode == HLT) ? HALT
                    : (SKIP_NOP && !(alu_op || opcode == LDA)) ? T1 : T5;
      T5:      next = (SKIP_NOP && !alu_op) ? T1 : T6;
      T6:      next = T1;
      HALT:    next = HALT;
      default: next = state + 3'd1;
    endcase
  end

  // Moore strobe decode; opcode only matters in T4..T6, so at most one bus driver per state
  always_comb begin
    pc_inc     = 1'b0;
    n_pc_en    = 1'b1;
    n_mar_load = 1'b1;
    n_ram_en   = 1'b1;
    n_ir_load  = 1'b1;
    n_ir_en    = 1'b1;
    n_a_load   = 1'b1;
    n_a_en     = 1'b1;
    sub        = 1'b0;
    n_alu_en   = 1'b1;
    n_b_load   = 1'b1;
    n_out_load = 1'b1;
    case (state)
      T1: begin
        n_pc_en    = 1'b0;
        n_mar_load = 1'b0;
      end
      T2: pc_inc = 1'b1;
      T3: begin
        n_ram_en  = 1'b0;
        n_ir_load = 1'b0;
      end
      T4: begin
        n_ir_en    = !(alu_op || opcode == LDA);
        n_mar_load = !(alu_op || opcode == LDA);
        n_a_en     = !(opcode == OUT);
        n_out_load = !(opcode == OUT);
      end
      T5: begin
        n_ram_en = !(alu_op || opcode == LDA);
        n_a_load = !(opcode == LDA);
        n_b_load = !alu_op;
      end
      T6: begin
        n_alu_en = !alu_op;
        n_a_load = !alu_op;
        sub      = (opcode == SUB);
      end
      default: ;
    endcase
  end
endmodule

// File: doc/sap1_sequencer.md
Name: sap1_sequencer

Overview:
- Control sequencer for the SAP-1 8-bit shared-bus datapath.
- Steps a six-state T-cycle and drives the active-low load/enable strobes of PC, MAR, RAM, IR, A, B, ALU and output register, decoded from the IR opcode nibble.
- Guarantees at most one bus driver per cycle.
- Sits beside the register blocks; its outputs wire directly to their n_load/n_en pins.

Parameters:
- SKIP_NOP, 0, when 1 an instruction returns to T1 immediately after its last active T-state instead of idling through no-op T-states.

Ports:
- clk  input  1  system clock, rising-edge active.
- n_rst  input  1  asynchronous active-low reset.
- opcode  input  4  IR[7:4], valid from T4 through T6.
- pc_inc  output  1  PC increment (Cp), active-high.
- n_pc_en  output  1  PC drives bus (Ep), active-low.
- n_mar_load  output  1  MAR load (Lm), active-low.
- n_ram_en  output  1  RAM drives bus (CE), active-low.
- n_ir_load  output  1  IR load (Li), active-low.
- n_ir_en  output  1  IR low nibble drives bus (Ei), active-low.
- n_a_load  output  1  A load (La), active-low.
- n_a_en  output  1  A drives bus (Ea), active-low.
- sub  output  1  ALU subtract select (Su), active-high.
- n_alu_en  output  1  ALU drives bus (Eu), active-low.
- n_b_load  output  1  B load (Lb), active-low.
- n_out_load  output  1  output register load (Lo), active-low.
- tstate  output  3  current state: IDLE=0, T1..T6=1..6, HALT=7.
- halted  output  1  high in HALT.

Behaviour:
- One clock; reset is asynchronous and active-low on n_rst, clock port clk. Reset forces IDLE immediately.
- Active level: high for pc_inc and sub; low for every other strobe.
- Inactive strobes: pc_inc=0, sub=0, all n_* outputs=1.
- Reset values: tstate=0, halted=0, all strobes inactive.
- State register: 3 bits. Outputs are a Moore decode of the state plus the opcode input during T4–T6.
- Outputs are glitch-free relative to clk. No output depends combinationally on opcode outside T4–T6.
- Transitions:
  - IDLE→T1 on the first edge after n_rst deasserts.
  - Tn→Tn+1 for n<6; T6→T1.
  - HALT holds until reset.
- IDLE and HALT: all strobes inactive.
- Fetch, independent of opcode:
  - T1: n_pc_en=0, n_mar_load=0.
  - T2: pc_inc=1.
  - T3: n_ram_en=0, n_ir_load=0.
- Execute by opcode:
  - LDA 0000:
    - T4: n_ir_en=0, n_mar_load=0.
    - T5: n_ram_en=0, n_a_load=0.
    - T6: none.
  - ADD 0001:
    - T4: as LDA.
    - T5: n_ram_en=0, n_b_load=0.
    - T6: n_alu_en=0, n_a_load=0, sub=0.
  - SUB 0010: as ADD, but sub=1 in T6 only.
  - OUT 1110:
    - T4: n_a_en=0, n_out_load=0.
    - T5, T6: none.
  - HLT 1111: at T4 all strobes stay inactive; the next edge enters HALT, not T5.
  - Any other opcode: T4–T6 no-op, sequencer advances normally.
- SKIP_NOP=1: after LDA T5, the next state is T1. After OUT T4, and after undefined-opcode T4, the next state is T1. ADD/SUB still use T6.
- Bus exclusivity: n_pc_en, n_ram_en, n_ir_en, n_a_en, n_alu_en — at most one low in any state.
- Reset mid-instruction: immediate return to IDLE with strobes inactive. Restart from T1; no partial instruction resumes.
- An opcode change during T4–T6 is illegal stimulus. Behaviour is still defined: decode uses the current value each cycle.

Test Plan:
- Reset then 8 clocks, opcode=0000 → tstate 0,1,2,3,4,5,6,1,2. Strobes match the LDA table each cycle; pc_inc high only in T2.
- opcode=0001 held through T4–T6 → T5 n_b_load=0 and n_ram_en=0. T6 n_alu_en=0, n_a_load=0, sub=0. Repeat with 0010 → T6 sub=1, all else identical.
- opcode=1110 → T4 n_a_en=0, n_out_load=0. With SKIP_NOP=1 the state after T4 is T1; total instruction is 4 cycles.
- opcode=1111 → T4 all strobes inactive, then tstate=7, halted=1 for 20 clocks. Pulse n_rst low mid-cycle → tstate=0 asynchronously; next edge after release → T1.
- Random opcodes over 1000 cycles with both SKIP_NOP values → bus-driver one-hot check never fails.
- Assert n_rst during ADD T5 → outputs inactive immediately. After release, the sequence restarts at T1 with n_pc_en=0.
